// File: rtl/shift_sequencer_pkg.sv
// Shared types and constants for the rotate sequencer and its step counter.
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;
    localparam int   CNT_W     = 3;

endpackage

// File: rtl/shift_sequencer_step_cnt.sv
// Loadable down-counter tracking the remaining rotate steps; flags the final step.
module shift_step_cnt
    import shift_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             last_o
);

    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_d;

    always_comb begin
        rem_d = rem_q;
        if (load_i) begin
            rem_d = load_val_i;
        end else if (dec_i) begin
            rem_d = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q <= '0;
        end else begin
            rem_q <= rem_d;
        end
    end

    assign last_o = (rem_q == CNT_W'(1));

endmodule

// File: rtl/shift_sequencer.sv
// Sequences an external rotator: one pass-through or N single-bit rotate steps, then a done pulse.
module shift_sequencer
    import shift_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dir,
    input  logic [CNT_W-1:0] cnt,
    input  logic [7:0]       din,
    output logic             busy,
    output logic             done,
    output logic [7:0]       dout,
    output logic             cf_out,
    output logic             F_BUS,
    output logic             FL_BUS,
    output logic             FR_BUS,
    output logic [7:0]       a,
    input  logic [7:0]       W,
    input  logic             Cf
);

    state_e     state_q, state_d;
    logic [7:0] a_q, a_d;
    logic       dir_q, dir_d;
    logic       cf_q, cf_d;
    logic [7:0] dout_q, dout_d;
    logic       cf_out_q, cf_out_d;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_last;

    shift_step_cnt u_step_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt),
        .dec_i      (cnt_dec),
        .last_o     (cnt_last)
    );

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latches).
        state_d  = state_q;
        a_d      = a_q;
        dir_d    = dir_q;
        cf_d     = cf_q;
        dout_d   = dout_q;
        cf_out_d = cf_out_q;
        busy     = 1'b1;
        done     = 1'b0;
        F_BUS    = 1'b0;
        FL_BUS   = 1'b0;
        FR_BUS   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;

        unique case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    a_d      = din;
                    dir_d    = dir;
                    cnt_load = 1'b1;
                    state_d  = (cnt == '0) ? PASS : SHIFT;
                end
            end
            PASS: begin
                F_BUS   = 1'b1;
                a_d     = W;
                cf_d    = Cf;
                state_d = DONE;
            end
            SHIFT: begin
                FL_BUS  = (dir_q == DIR_LEFT);
                FR_BUS  = (dir_q == DIR_RIGHT);
                a_d     = W;
                cf_d    = Cf;
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Result registers capture on the edge that enters DONE, so they are already valid during done.
        if (state_d == DONE && state_q != DONE) begin
            dout_d   = a_d;
            cf_out_d = cf_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= 8'h00;
            dir_q    <= DIR_LEFT;
            cf_q     <= 1'b0;
            dout_q   <= 8'h00;
            cf_out_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            dir_q    <= dir_d;
            cf_q     <= cf_d;
            dout_q   <= dout_d;
            cf_out_q <= cf_out_d;
        end
    end

    assign a      = a_q;
    assign dout   = dout_q;
    assign cf_out = cf_out_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench: real 8-bit rotator on the strobe bus, queue-based expectation model, directed and random ops.
module tb_shift_sequencer;
    import shift_sequencer_pkg::*;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       dir   = 1'b0;
    logic [2:0] cnt   = 3'd0;
    logic [7:0] din   = 8'h00;
    logic       busy, done, cf_out, F_BUS, FL_BUS, FR_BUS, Cf;
    logic [7:0] dout, a, W;

    always #5 clk = ~clk;

    shift_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .dir    (dir),
        .cnt    (cnt),
        .din    (din),
        .busy   (busy),
        .done   (done),
        .dout   (dout),
        .cf_out (cf_out),
        .F_BUS  (F_BUS),
        .FL_BUS (FL_BUS),
        .FR_BUS (FR_BUS),
        .a      (a),
        .W      (W),
        .Cf     (Cf)
    );

    // External rotator: pass-through, rotate-left or rotate-right by one bit.
    always_comb begin
        W  = a;
        Cf = 1'b0;
        if (FL_BUS) begin
            W  = {a[6:0], a[7]};
            Cf = a[7];
        end else if (FR_BUS) begin
            W  = {a[0], a[7:1]};
            Cf = a[0];
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Expected per-cycle outputs, queued up when the model accepts an operation.
    typedef struct packed {
        logic       busy;
        logic       done;
        logic       f;
        logic       fl;
        logic       fr;
        logic [7:0] a;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       cur      = '0;
    logic [7:0] exp_dout = 8'h00;
    logic       exp_cf   = 1'b0;
    logic [7:0] op_res   = 8'h00;
    logic       op_cf    = 1'b0;

    function automatic logic [7:0] rot(input logic [7:0] v, input int n, input logic right);
        logic [15:0] w;
        w = {v, v};
        if (right) begin
            w = w >> n;
            return w[7:0];
        end
        w = w << n;
        return w[15:8];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            cur      = '0;
            exp_dout = 8'h00;
            exp_cf   = 1'b0;
        end else begin
            if (exp_q.size() == 0 && start) begin
                op_res = rot(din, int'(cnt), dir);
                op_cf  = (cnt == 3'd0) ? 1'b0 : (dir ? op_res[7] : op_res[0]);
                if (cnt == 3'd0) begin
                    e = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, din};
                    exp_q.push_back(e);
                end else begin
                    for (int i = 0; i < int'(cnt); i++) begin
                        e = {1'b1, 1'b0, 1'b0, ~dir, dir, rot(din, i, dir)};
                        exp_q.push_back(e);
                    end
                end
                e = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, op_res};
                exp_q.push_back(e);
                e = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, op_res};
                exp_q.push_back(e);
            end
            if (exp_q.size() > 0) begin
                cur = exp_q.pop_front();
                if (cur.done) begin
                    exp_dout = op_res;
                    exp_cf   = op_cf;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("busy",   busy,   cur.busy);
        check("done",   done,   cur.done);
        check("F_BUS",  F_BUS,  cur.f);
        check("FL_BUS", FL_BUS, cur.fl);
        check("FR_BUS", FR_BUS, cur.fr);
        check("a",      a,      cur.a);
        check("dout",   dout,   exp_dout);
        check("cf_out", cf_out, exp_cf);
        check("strobe_onehot", ($countones({F_BUS, FL_BUS, FR_BUS}) <= 1), 1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one operation and pins its literal result, latency and strobe count.
    task automatic run_op(input string tag, input logic [7:0] d, input logic dr, input logic [2:0] c,
                          input logic [7:0] exp_d, input logic exp_c, input int exp_lat, input int inject_at);
        int lat     = 0;
        int strobes = 0;
        bit seen    = 0;
        din   = d;
        dir   = dr;
        cnt   = c;
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 1;
        din   = 8'($urandom);
        dir   = 1'($urandom);
        cnt   = 3'($urandom);
        if (F_BUS | FL_BUS | FR_BUS) strobes++;
        while (!seen && lat < 20) begin
            if (lat == inject_at) begin
                start = 1'b1;
                din   = 8'hFF;
            end
            tick();
            lat++;
            start = 1'b0;
            if (done) seen = 1;
            else if (F_BUS | FL_BUS | FR_BUS) strobes++;
        end
        check({tag, "_done_seen"}, seen, 1);
        if (seen) begin
            check({tag, "_latency"}, lat, exp_lat);
            check({tag, "_dout"}, dout, exp_d);
            check({tag, "_cf_out"}, cf_out, exp_c);
            check({tag, "_strobe_cycles"}, strobes, (c == 3'd0) ? 1 : int'(c));
        end
        tick();
    endtask

    initial begin
        #3;
        check("reset_busy", busy, 0);
        check("reset_dout", dout, 8'h00);
        check("reset_a", a, 8'h00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        run_op("rol1",   8'h81, 1'b0, 3'd1, 8'h03, 1'b1, 2, -1);
        run_op("ror1",   8'h81, 1'b1, 3'd1, 8'hC0, 1'b1, 2, -1);
        run_op("rol4",   8'hA5, 1'b0, 3'd4, 8'h5A, 1'b0, 5, -1);
        run_op("pass",   8'h3C, 1'b1, 3'd0, 8'h3C, 1'b0, 2, -1);
        run_op("ignore", 8'hA5, 1'b0, 3'd4, 8'h5A, 1'b0, 5, 2);

        // Abort a 7-step rotate during its third shift cycle.
        din   = 8'h5B;
        dir   = 1'b0;
        cnt   = 3'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("abort_strobes", {F_BUS, FL_BUS, FR_BUS}, 3'b000);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_dout", dout, 8'h00);
        check("abort_a", a, 8'h00);
        repeat (3) begin
            tick();
            check("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        run_op("post_rst", 8'h81, 1'b1, 3'd1, 8'hC0, 1'b1, 2, -1);

        repeat (400) begin
            start = ($urandom_range(2) == 0);
            din   = 8'($urandom);
            dir   = 1'($urandom);
            cnt   = 3'($urandom);
            tick();
        end
        start = 1'b0;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL provide one clock and an asynchronous active-low reset.
REQ-002 The port list SHALL be as follows, clock and reset first:
- clk  in  1  sole clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a rotate operation; sampled only in IDLE.
- dir  in  1  0 = rotate left, 1 = rotate right.
- cnt  in  3  number of single-bit rotations, 0..7.
- din  in  8  operand.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- dout  out  8  result; valid from the done cycle until the next done.
- cf_out  out  1  carry of the last step; valid alongside dout.
- F_BUS  out  1  shifter pass-through strobe.
- FL_BUS  out  1  shifter rotate-left strobe.
- FR_BUS  out  1  shifter rotate-right strobe.
- a  out  8  operand driven to the shifter; equals the internal a_reg.
- W  in  8  shifter result, combinational from a and the strobes.
- Cf  in  1  shifter carry, combinational.

Function
REQ-003 The block SHALL implement the states IDLE, PASS, SHIFT and DONE.
REQ-004 In IDLE, all strobes SHALL be 0 and busy SHALL be 0.
REQ-005 At an edge in IDLE with start=1, the block SHALL latch din into a_reg, latch dir into dir_reg and load rem with cnt.
- If cnt=0, the next state SHALL be PASS.
- Otherwise, the next state SHALL be SHIFT.
REQ-006 In PASS, F_BUS SHALL be 1 for exactly one cycle.
- At the closing edge, a_reg<=W and cf_reg<=Cf.
- The next state SHALL be DONE.
REQ-007 In SHIFT, FL_BUS (dir_reg=0) or FR_BUS (dir_reg=1) SHALL be 1 for the whole cycle.
- At each edge, a_reg<=W, cf_reg<=Cf and rem<=rem-1.
- When rem=1 at the edge, the next state SHALL be DONE; otherwise SHIFT continues.
REQ-008 In DONE, done SHALL be 1 for one cycle and all strobes SHALL be 0.
- dout SHALL be a_reg and cf_out SHALL be cf_reg.
- The next state SHALL be IDLE unconditionally.
REQ-009 dout and cf_out SHALL be registered and hold their values until the next DONE.
REQ-010 At most one of F_BUS, FL_BUS and FR_BUS SHALL be 1 in any cycle.
REQ-011 Latency: for start sampled at edge k, done SHALL be high in cycle k+max(cnt,1)+1.
REQ-012 busy SHALL rise in the cycle after start is accepted and fall in the cycle after DONE.
REQ-013 start SHALL be ignored while busy=1; inputs sampled at acceptance SHALL NOT be affected by later changes to din, dir or cnt.
REQ-014 Back-to-back operation: start=1 in the first IDLE cycle after DONE SHALL be accepted.
REQ-015 For cnt=0, dout SHALL equal din and cf_out SHALL be 0.

Reset
REQ-016 While rst_n=0, the block SHALL force the following values asynchronously, with no clock required:
- state=IDLE, busy=0, done=0;
- all strobes 0;
- a_reg=0x00, rem=0;
- dout=0x00, cf_out=0, cf_reg=0.
REQ-017 Reset asserted during PASS or SHIFT SHALL abort the operation with no done pulse; strobes SHALL drop within the same cycle.
REQ-018 After rst_n deasserts, the first start SHALL be accepted at the first rising edge.

Structure
REQ-019 A shared package SHALL hold:
- the state enumeration (IDLE, PASS, SHIFT, DONE);
- constants DIR_LEFT=0 and DIR_RIGHT=1;
- constant CNT_W=3.
REQ-020 The step counter SHALL be a sub-module shift_step_cnt, a loadable 3-bit down-counter with a last-step flag.
REQ-021 The shifter SHALL be external; this block SHALL contain no shift logic of its own.

Verification
REQ-022 The bench SHALL connect the real shifter to a/W/Cf/strobes and cover:
- din=0x81, dir=0, cnt=1 -> one FL_BUS cycle; dout=0x03, cf_out=1; done at k+2.
- din=0x81, dir=1, cnt=1 -> dout=0xC0, cf_out=1.
- din=0xA5, dir=0, cnt=4 -> four FL_BUS cycles; dout=0x5A, cf_out=0; done at k+5.
- din=0x3C, cnt=0 -> one F_BUS cycle; dout=0x3C, cf_out=0; done at k+2.
- start pulsed mid-SHIFT with new din=0xFF -> ignored; the original result is unchanged.
- rst_n low during cycle 3 of cnt=7 -> strobes 0 immediately; no done; dout=0x00; the next start completes normally.
